// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: streams x/w addresses into an external 3-cycle MAC,
// drains the pipeline, then writes one accumulated result per output neuron.
module dot_product_ctrl #(
   parameter int LEN  = 8,
   parameter int OUTS = 4,
   parameter int AW   = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW-1:0] x_addr,
   input  logic [7:0]    x_data,
   output logic [AW-1:0] w_addr,
   input  logic [7:0]    w_data,
   output logic          mac_clr,
   output logic          mac_valid,
   output logic [7:0]    mac_a,
   output logic [7:0]    mac_b,
   input  logic [15:0]   mac_f,
   input  logic          mac_valid_out,
   output logic          y_wr,
   output logic [AW-1:0] y_addr,
   output logic [15:0]   y_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [7:0]    j_q, j_d;
   logic [7:0]    k_q, k_d;
   logic [7:0]    c_q, c_d;
   logic [2:0]    t_q, t_d;
   logic [AW-1:0] wb_q, wb_d;
   logic          mv_q, mv_d;
   logic          err_q, err_d;
   logic [8:0]    c_inc;

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      k_d     = k_q;
      c_d     = c_q;
      t_d     = t_q;
      wb_d    = wb_q;
      err_d   = err_q;
      mv_d    = (state_q == S_ISSUE);
      c_inc   = {1'b0, c_q} + 9'(mac_valid_out);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               j_d     = 8'd0;
               wb_d    = '0;
               err_d   = 1'b0;
            end
         end
         S_CLEAR: begin
            k_d     = 8'd0;
            c_d     = 8'd0;
            t_d     = 3'd0;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            c_d = c_inc[7:0];
            if (k_q == 8'(LEN - 1)) state_d = S_DRAIN;
            else k_d = k_q + 8'd1;
         end
         S_DRAIN: begin
            c_d = c_inc[7:0];
            t_d = t_q + 3'd1;
            // completion wins over timeout on the 8th drain cycle
            if (c_inc == 9'(LEN)) begin
               state_d = S_WRITE;
            end else if (t_q == 3'd7) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_WRITE: begin
            if (j_q == 8'(OUTS - 1)) begin
               state_d = S_DONE;
            end else begin
               j_d     = j_q + 8'd1;
               wb_d    = wb_q + AW'(LEN);
               state_d = S_CLEAR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         j_q     <= 8'd0;
         k_q     <= 8'd0;
         c_q     <= 8'd0;
         t_q     <= 3'd0;
         wb_q    <= '0;
         mv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         k_q     <= k_d;
         c_q     <= c_d;
         t_q     <= t_d;
         wb_q    <= wb_d;
         mv_q    <= mv_d;
         err_q   <= err_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;
   assign x_addr    = (state_q == S_ISSUE) ? AW'(k_q) : '0;
   assign w_addr    = (state_q == S_ISSUE) ? wb_q + AW'(k_q) : '0;
   assign mac_clr   = reset | (state_q == S_CLEAR);
   assign mac_valid = mv_q;
   assign mac_a     = x_data;
   assign mac_b     = w_data;
   assign y_wr      = (state_q == S_WRITE);
   assign y_addr    = y_wr ? AW'(j_q) : '0;
   assign y_data    = y_wr ? mac_f : 16'd0;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed bench: two controller instances, each with memories and a
// behavioural 3-cycle MAC; checks results, timing, reset and timeout.
module tb_dot_product_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   tests = 0;
   int   fails = 0;

   // instance 0: LEN=4, OUTS=2
   logic        start0, busy0, done0, err0;
   logic [7:0]  x_addr0, w_addr0, x_data0, w_data0;
   logic        mac_clr0, mac_valid0, mvo0, y_wr0;
   logic [7:0]  mac_a0, mac_b0, y_addr0;
   logic [15:0] mac_f0, y_data0;
   logic signed [7:0] xmem0 [0:255];
   logic signed [7:0] wmem0 [0:255];
   logic [15:0] p1_0, p2_0, acc0;
   logic        v1_0, v2_0, vo0, kill0;

   // instance 1: LEN=1, OUTS=1
   logic        start1, busy1, done1, err1;
   logic [7:0]  x_addr1, w_addr1, x_data1, w_data1;
   logic        mac_clr1, mac_valid1, mvo1, y_wr1;
   logic [7:0]  mac_a1, mac_b1, y_addr1;
   logic [15:0] mac_f1, y_data1;
   logic [15:0] p1_1, p2_1, acc1;
   logic        v1_1, v2_1, vo1;

   dot_product_ctrl #(.LEN(4), .OUTS(2), .AW(8)) u0 (
      .clk(clk), .reset(reset), .start(start0), .busy(busy0),
      .done(done0), .err(err0), .x_addr(x_addr0), .x_data(x_data0),
      .w_addr(w_addr0), .w_data(w_data0), .mac_clr(mac_clr0),
      .mac_valid(mac_valid0), .mac_a(mac_a0), .mac_b(mac_b0),
      .mac_f(mac_f0), .mac_valid_out(mvo0), .y_wr(y_wr0),
      .y_addr(y_addr0), .y_data(y_data0)
   );

   dot_product_ctrl #(.LEN(1), .OUTS(1), .AW(8)) u1 (
      .clk(clk), .reset(reset), .start(start1), .busy(busy1),
      .done(done1), .err(err1), .x_addr(x_addr1), .x_data(x_data1),
      .w_addr(w_addr1), .w_data(w_data1), .mac_clr(mac_clr1),
      .mac_valid(mac_valid1), .mac_a(mac_a1), .mac_b(mac_b1),
      .mac_f(mac_f1), .mac_valid_out(mvo1), .y_wr(y_wr1),
      .y_addr(y_addr1), .y_data(y_data1)
   );

   // synchronous-read memories
   always @(posedge clk) begin
      x_data0 <= xmem0[x_addr0];
      w_data0 <= wmem0[w_addr0];
      x_data1 <= (x_addr1 == 8'd0) ? 8'h80 : 8'h00;
      w_data1 <= (w_addr1 == 8'd0) ? 8'h80 : 8'h00;
   end

   // MAC models: product visible with valid_out 3 cycles after valid_in
   always @(posedge clk) begin
      if (mac_clr0) begin
         v1_0 <= 0; v2_0 <= 0; vo0 <= 0; acc0 <= 0;
      end else begin
         p1_0 <= $signed(mac_a0) * $signed(mac_b0);
         v1_0 <= mac_valid0;
         p2_0 <= p1_0;
         v2_0 <= v1_0;
         if (v2_0) acc0 <= acc0 + p2_0;
         vo0 <= v2_0;
      end
      if (mac_clr1) begin
         v1_1 <= 0; v2_1 <= 0; vo1 <= 0; acc1 <= 0;
      end else begin
         p1_1 <= $signed(mac_a1) * $signed(mac_b1);
         v1_1 <= mac_valid1;
         p2_1 <= p1_1;
         v2_1 <= v1_1;
         if (v2_1) acc1 <= acc1 + p2_1;
         vo1 <= v2_1;
      end
   end
   assign mac_f0 = acc0;
   assign mvo0   = vo0 & ~kill0;
   assign mac_f1 = acc1;
   assign mvo1   = vo1;

   // result / done monitors
   logic [15:0] ylog [0:3];
   int wr_cnt, done_cnt, err_at_done;
   always @(negedge clk) begin
      if (y_wr0) begin
         if (y_addr0 < 8'd4) ylog[y_addr0[1:0]] = y_data0;
         wr_cnt++;
      end
      if (done0) begin
         done_cnt++;
         err_at_done = int'(err0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_logs();
      for (int i = 0; i < 4; i++) ylog[i] = 16'hDEAD;
      wr_cnt = 0;
      done_cnt = 0;
      err_at_done = -1;
   endtask

   // start one run on u0; optionally pulse start while busy
   task automatic run0(input bit pulse, output int cyc);
      bit seen;
      clr_logs();
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      cyc = 0;
      seen = 0;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start0 = pulse && (cyc == 3 || cyc == 7 || cyc == 12);
         if (done0) seen = 1;
      end
      start0 = 1'b0;
      chk("run_done_seen", 32'(seen), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   int cyc;

   initial begin
      reset  = 1'b1;
      start0 = 1'b1;
      start1 = 1'b1;
      kill0  = 1'b0;
      for (int i = 0; i < 256; i++) begin
         xmem0[i] = 8'sd0;
         wmem0[i] = 8'sd0;
      end
      xmem0[0] = 1; xmem0[1] = 2; xmem0[2] = 3; xmem0[3] = 4;
      for (int i = 0; i < 4; i++) wmem0[i] = 1;
      wmem0[4] = -1; wmem0[5] = 2; wmem0[6] = -3; wmem0[7] = 4;
      clr_logs();

      // reset state, start held high during reset
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_outs", {busy0, done0, err0, y_wr0, mac_valid0},
          32'd0);
      chk("rst_addr", {x_addr0, w_addr0}, 32'd0);
      chk("rst_clr", 32'(mac_clr0), 32'd1);
      chk("rst_u1", {busy1, done1, err1, y_wr1}, 32'd0);
      start0 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_after_rst", 32'(busy0), 32'd0);
      start1 = 1'b0;

      // basic two-neuron run
      run0(1'b0, cyc);
      chk("basic_y0", 32'(ylog[0]), 32'd10);
      chk("basic_y1", 32'(ylog[1]), 32'd10);
      chk("basic_wr", 32'(wr_cnt), 32'd2);
      chk("basic_done", 32'(done_cnt), 32'd1);
      chk("basic_err", 32'(err_at_done), 32'd0);
      chk("basic_len", 32'(cyc), 32'd21);
      chk("basic_idle", 32'(busy0), 32'd0);

      // start pulses while busy are ignored
      run0(1'b1, cyc);
      chk("busy_wr", 32'(wr_cnt), 32'd2);
      chk("busy_done", 32'(done_cnt), 32'd1);
      chk("busy_len", 32'(cyc), 32'd21);
      repeat (3) @(negedge clk);
      chk("busy_no_rerun", 32'(busy0), 32'd0);

      // 16-bit wrap: 4*127*127 = 64516 -> -1020
      for (int i = 0; i < 8; i++) begin
         xmem0[i] = 8'sd127;
         wmem0[i] = 8'sd127;
      end
      run0(1'b0, cyc);
      chk("wrap_y0", 32'(ylog[0]), 32'h0000FC04);
      chk("wrap_y1", 32'(ylog[1]), 32'h0000FC04);

      // reset during ISSUE of j=1, then a clean rerun
      xmem0[0] = 1; xmem0[1] = 2; xmem0[2] = 3; xmem0[3] = 4;
      for (int i = 0; i < 4; i++) wmem0[i] = 1;
      wmem0[4] = -1; wmem0[5] = 2; wmem0[6] = -3; wmem0[7] = 4;
      clr_logs();
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      cyc = 0;
      while (!y_wr0 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("mid_first_wr", 32'(y_wr0), 32'd1);
      repeat (3) @(negedge clk);
      chk("mid_in_issue", 32'(mac_valid0), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_outs",
          {busy0, done0, err0, y_wr0, mac_valid0}, 32'd0);
      chk("mid_rst_addr", {x_addr0, w_addr0, y_data0}, 32'd0);
      reset = 1'b0;
      run0(1'b0, cyc);
      chk("mid_y0", 32'(ylog[0]), 32'd10);
      chk("mid_y1", 32'(ylog[1]), 32'd10);
      chk("mid_wr", 32'(wr_cnt), 32'd2);

      // drain timeout: no completions ever reach the controller
      kill0 = 1'b1;
      run0(1'b0, cyc);
      chk("to_len", 32'(cyc), 32'd14);
      chk("to_err", 32'(err_at_done), 32'd1);
      chk("to_no_wr", 32'(wr_cnt), 32'd0);
      chk("to_err_held", 32'(err0), 32'd1);
      kill0 = 1'b0;
      run0(1'b0, cyc);
      chk("to_recover_err", 32'(err_at_done), 32'd0);
      chk("to_recover_y1", 32'(ylog[1]), 32'd10);

      // LEN=1 OUTS=1: (-128)*(-128) = 16384, 8-cycle run
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      cyc = 0;
      begin
         bit seen1;
         logic [15:0] y1;
         seen1 = 0;
         y1 = 16'hDEAD;
         while (!seen1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (y_wr1) y1 = y_data1;
            if (done1) seen1 = 1;
         end
         chk("len1_done", 32'(seen1), 32'd1);
         chk("len1_y", 32'(y1), 32'd16384);
         chk("len1_len", 32'(cyc), 32'd8);
         chk("len1_err", 32'(err1), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
